lms_err_ctrl: RTL and testbench
===============================

# lms_err_ctrl

Initiator and error path for the 16-tap LMS noise canceller. Accepts paired (reference-noise, primary) samples on a valid/ready stream and launches one filter iteration per sample via the filter's `en_i`/`update` handshake. On completion it forms the cancelled output e = d − y, emits it downstream, and drives the step-scaled error back to the filter's `err` input for the next iteration. Sits between the ADC sample front-end and the LMS filter, and is the other end of the filter's control interface.

## Interface
- X_W, 16, reference-noise sample width (filter `xin`)
- D_W, 16, primary (desired) sample width; same fixed-point format as filter `yout`
- Y_W, 16, filter output width
- E_W, 16, error and cancelled-output width
- MU_SH, 4, step size as an arithmetic right shift applied to the fed-back error
- TO_W, 8, width of the update-timeout counter
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample pair valid
- s_ready  out  1  block can accept a sample pair
- s_xin  in  X_W  reference-noise sample, signed
- s_din  in  D_W  primary sample, signed
- f_en  out  1  one-cycle start pulse to the filter (`en_i`)
- f_xin  out  X_W  sample presented to the filter (`xin`)
- f_err  out  E_W  fed-back, step-scaled error (`err`)
- f_update  in  1  filter iteration done (`update`)
- f_yout  in  Y_W  filter estimate (`yout`), valid with f_update
- m_valid  out  1  cancelled output valid
- m_ready  in  1  downstream accepts
- m_eout  out  E_W  cancelled output sat(d − y)
- m_yout  out  Y_W  captured filter estimate, debug
- timeout  out  1  one-cycle pulse: filter did not answer

## Operation
- FSM states: IDLE, ISSUE, WAIT, CALC, OUT. Reset state is IDLE.
- IDLE: s_ready=1. On s_valid & s_ready, latch s_xin into x_r and s_din into d_r, then go to ISSUE.
- ISSUE: f_en=1 for exactly one cycle. f_xin=x_r, held until the next ISSUE. Go to WAIT and clear the timeout counter.
- WAIT: the counter increments each cycle.
  - On f_update=1: capture f_yout into y_r and go to CALC.
  - If the counter reaches 2^TO_W−1 without f_update: pulse timeout, go to IDLE. f_err is unchanged and no output is produced.
  - f_update takes priority over timeout in the same cycle.
- CALC:
  - diff = sign-extended d_r − sign-extended y_r, computed at max(D_W,Y_W)+1 bits.
  - Saturate to E_W: clamp to +2^(E_W−1)−1 / −2^(E_W−1).
  - m_eout ← sat.
  - f_err ← sat >>> MU_SH (arithmetic shift, truncated toward −∞).
  - Go to OUT.
- OUT: m_valid=1, holding m_eout and m_yout stable until m_ready. On m_valid & m_ready, go to IDLE.
- f_update outside WAIT is ignored.
- f_err changes only in CALC. The filter therefore always sees the error of iteration n−1 while processing sample n; the first iteration sees 0.
- Reset mid-operation: everything returns to reset values immediately. Any f_update arriving after reset release is ignored because the FSM is in IDLE.

## Timing
- Reset values: s_ready=1, f_en=0, f_xin=0, f_err=0, m_valid=0, m_eout=0, m_yout=0, timeout=0.
- s_ready, f_en and m_valid are decoded from the state register; all datapath outputs are registered.
- Input handshake at edge k: f_en is high in cycle k+1 only.
- f_update seen at edge u: CALC occupies cycle u+1; m_valid rises at cycle u+2.
- Minimum sample period is 5 cycles plus filter latency, plus any m_ready stall.
- Timeout pulse occurs 2^TO_W−1 cycles after entering WAIT.
- Back-pressure: no new sample is accepted until the output is consumed; there is no internal FIFO.

## Structure
- Shared package `lms_pkg`:
  - state enum
  - saturation helper function (width-generic via parameters)
  - default width constants X_W/D_W/Y_W/E_W
- One sub-module: `lms_sat_sub`, a combinational signed subtract plus saturate to E_W, instanced in the CALC datapath.
- FSM, counter and registers live in the top.

## Test plan
- Reset, then s_xin=100, s_din=1000; model filter answers 3 cycles after f_en with f_yout=400 -> f_en pulses once; m_eout=600, m_yout=400; f_err=600>>>4=37; m_valid 2 cycles after f_update.
- d=−32768, y=+32767 -> diff saturates: m_eout=−32768, f_err=−2048. d=32767, y=−32768 -> m_eout=32767, f_err=2047.
- d=−5, y=0, MU_SH=4 -> m_eout=−5, f_err=−1 (floor); a second sample launched afterwards sees f_err=−1 during its f_en.
- Model never asserts f_update -> timeout pulses exactly 255 cycles after entering WAIT; FSM returns to IDLE with f_err unchanged and m_valid never asserted.
- m_ready held low 10 cycles in OUT -> m_valid and m_eout stable, s_ready=0, an s_valid sample is not accepted; release -> one transfer, s_ready=1 next cycle.
- rst_n asserted during WAIT, then a stray f_update after release -> all outputs at reset values, no CALC, no m_valid.

Source files
------------

// File: rtl/lms_pkg.sv
// lms_pkg: shared widths, FSM state encoding and saturation helper for the LMS error path.
package lms_pkg;
    localparam int DEF_X_W = 16;
    localparam int DEF_D_W = 16;
    localparam int DEF_Y_W = 16;
    localparam int DEF_E_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CALC  = 3'd3,
        OUT   = 3'd4
    } state_e;

    // Clamp a signed value to the range of a w-bit two's complement number (w <= 32).
    function automatic logic signed [32:0] sat_ew(input logic signed [32:0] v, input int w);
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction
endpackage

// File: rtl/lms_sat_sub.sv
// lms_sat_sub: signed d - y at full precision, saturated to E_W bits.
module lms_sat_sub import lms_pkg::*; #(
    parameter int D_W = DEF_D_W,
    parameter int Y_W = DEF_Y_W,
    parameter int E_W = DEF_E_W
) (
    input  logic signed [D_W-1:0] d,
    input  logic signed [Y_W-1:0] y,
    output logic signed [E_W-1:0] e
);
    localparam int M_W = (D_W > Y_W ? D_W : Y_W) + 1;
    logic signed [M_W-1:0] diff;
    assign diff = M_W'(d) - M_W'(y);
    assign e = E_W'(sat_ew(33'(diff), E_W));
endmodule

// File: rtl/lms_err_ctrl.sv
// lms_err_ctrl: launches one LMS filter iteration per sample pair, forms sat(d - y)
// and feeds the step-scaled error back to the filter for the next iteration.
module lms_err_ctrl import lms_pkg::*; #(
    parameter int X_W   = DEF_X_W,
    parameter int D_W   = DEF_D_W,
    parameter int Y_W   = DEF_Y_W,
    parameter int E_W   = DEF_E_W,
    parameter int MU_SH = 4,
    parameter int TO_W  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [X_W-1:0] s_xin,
    input  logic [D_W-1:0] s_din,
    output logic           f_en,
    output logic [X_W-1:0] f_xin,
    output logic [E_W-1:0] f_err,
    input  logic           f_update,
    input  logic [Y_W-1:0] f_yout,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [E_W-1:0] m_eout,
    output logic [Y_W-1:0] m_yout,
    output logic           timeout
);
    // Counter value one below all-ones: the edge that would take it to all-ones ends WAIT.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_e                state;
    logic [TO_W-1:0]       cnt;
    logic [D_W-1:0]        d_r;
    logic signed [E_W-1:0] e;

    assign s_ready = state == IDLE;
    assign f_en    = state == ISSUE;
    assign m_valid = state == OUT;

    lms_sat_sub #(.D_W(D_W), .Y_W(Y_W), .E_W(E_W)) u_sat (
        .d (d_r),
        .y (m_yout),
        .e (e)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            d_r     <= '0;
            f_xin   <= '0;
            f_err   <= '0;
            m_eout  <= '0;
            m_yout  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: if (s_valid) begin
                    f_xin <= s_xin;
                    d_r   <= s_din;
                    state <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (f_update) begin
                        m_yout <= f_yout;
                        state  <= CALC;
                    end else if (cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end
                end
                CALC: begin
                    m_eout <= e;
                    f_err  <= e >>> MU_SH;
                    state  <= OUT;
                end
                OUT: if (m_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lms_err_ctrl.sv
// tb_lms_err_ctrl: directed checks of lms_err_ctrl with a simple filter responder.
module tb_lms_err_ctrl;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_xin = '0;
    logic signed [15:0] s_din = '0;
    logic               f_en;
    logic signed [15:0] f_xin;
    logic signed [15:0] f_err;
    logic               f_update = 1'b0;
    logic signed [15:0] f_yout = '0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic signed [15:0] m_eout;
    logic signed [15:0] m_yout;
    logic               timeout;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;

    always #5 clk = ~clk;
    always @(negedge clk) en_cnt += int'(f_en);

    lms_err_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_xin(s_xin), .s_din(s_din),
        .f_en(f_en), .f_xin(f_xin), .f_err(f_err), .f_update(f_update), .f_yout(f_yout),
        .m_valid(m_valid), .m_ready(m_ready), .m_eout(m_eout), .m_yout(m_yout),
        .timeout(timeout)
    );

    // One full iteration; the filter answers lat cycles after the f_en cycle.
    task automatic iter(input int x, input int d, input int y, input int lat,
                        output int fe, output int xo, output int en_n, output int dly,
                        output int eo, output int yo, output int fo, output int sr);
        int e0;
        e0 = en_cnt;
        @(negedge clk);
        s_valid = 1'b1; s_xin = 16'(x); s_din = 16'(d);
        @(negedge clk);
        s_valid = 1'b0;
        fe = int'(f_err); xo = int'(f_xin);
        repeat (lat) @(negedge clk);
        f_update = 1'b1; f_yout = 16'(y);
        @(negedge clk);
        f_update = 1'b0;
        dly = 1;
        while (!m_valid && dly < 20) begin
            @(negedge clk);
            dly++;
        end
        eo = int'(m_eout); yo = int'(m_yout); fo = int'(f_err);
        en_n = en_cnt - e0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        sr = int'(s_ready && !m_valid);
    endtask

    task automatic test_reset;
        checks++;
        if ({s_ready, f_en, m_valid, timeout} !== 4'b1000 || f_xin !== 16'sd0 ||
            f_err !== 16'sd0 || m_eout !== 16'sd0 || m_yout !== 16'sd0) begin
            errors++;
            $display("FAIL reset: rdy/en/val/to=%b%b%b%b xin=%0d err=%0d eout=%0d yout=%0d",
                     s_ready, f_en, m_valid, timeout, f_xin, f_err, m_eout, m_yout);
        end
    endtask

    task automatic test_basic;
        int fe, xo, en_n, dly, eo, yo, fo, sr;
        iter(100, 1000, 400, 3, fe, xo, en_n, dly, eo, yo, fo, sr);
        checks++; if (fe !== 0 || xo !== 100) begin errors++; $display("FAIL basic_issue: f_err=%0d f_xin=%0d want 0 100", fe, xo); end
        checks++; if (en_n !== 1) begin errors++; $display("FAIL basic_en_pulses: got %0d want 1", en_n); end
        checks++; if (dly !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", dly); end
        checks++; if (eo !== 600 || yo !== 400) begin errors++; $display("FAIL basic_out: eout=%0d yout=%0d want 600 400", eo, yo); end
        checks++; if (fo !== 37) begin errors++; $display("FAIL basic_ferr: got %0d want 37", fo); end
        checks++; if (sr !== 1) begin errors++; $display("FAIL basic_release: got %0d want 1", sr); end
    endtask

    task automatic test_saturate;
        int fe, xo, en_n, dly, eo, yo, fo, sr;
        iter(1, -32768, 32767, 1, fe, xo, en_n, dly, eo, yo, fo, sr);
        checks++; if (fe !== 37) begin errors++; $display("FAIL sat_prev_err: got %0d want 37", fe); end
        checks++; if (eo !== -32768 || fo !== -2048) begin errors++; $display("FAIL sat_neg: eout=%0d err=%0d want -32768 -2048", eo, fo); end
        iter(2, 32767, -32768, 2, fe, xo, en_n, dly, eo, yo, fo, sr);
        checks++; if (fe !== -2048) begin errors++; $display("FAIL sat_prev_err2: got %0d want -2048", fe); end
        checks++; if (eo !== 32767 || fo !== 2047 || yo !== -32768) begin errors++; $display("FAIL sat_pos: eout=%0d err=%0d yout=%0d want 32767 2047 -32768", eo, fo, yo); end
    endtask

    task automatic test_floor;
        int fe, xo, en_n, dly, eo, yo, fo, sr;
        iter(3, -5, 0, 1, fe, xo, en_n, dly, eo, yo, fo, sr);
        checks++; if (eo !== -5 || fo !== -1) begin errors++; $display("FAIL floor: eout=%0d err=%0d want -5 -1", eo, fo); end
        iter(7, 20, 4, 4, fe, xo, en_n, dly, eo, yo, fo, sr);
        checks++; if (fe !== -1 || xo !== 7) begin errors++; $display("FAIL floor_next: f_err=%0d f_xin=%0d want -1 7", fe, xo); end
        checks++; if (eo !== 16 || fo !== 1 || dly !== 2) begin errors++; $display("FAIL floor_next_out: eout=%0d err=%0d dly=%0d want 16 1 2", eo, fo, dly); end
    endtask

    task automatic test_timeout;
        int n, first, mv, early;
        @(negedge clk);
        s_valid = 1'b1; s_xin = 16'sd11; s_din = 16'sd22;
        @(negedge clk);
        s_valid = 1'b0;
        n = 0; first = -1; mv = 0; early = 0;
        while (first < 0 && n < 400) begin
            @(negedge clk);
            n++;
            mv |= int'(m_valid);
            if (timeout) first = n;
        end
        checks++; if (first !== 256) begin errors++; $display("FAIL timeout_time: got %0d want 256", first); end
        checks++; if (s_ready !== 1'b1 || f_err !== 16'sd1) begin errors++; $display("FAIL timeout_state: s_ready=%b f_err=%0d want 1 1", s_ready, f_err); end
        @(negedge clk);
        early = int'(timeout);
        checks++; if (early !== 0 || mv !== 0 || m_valid !== 1'b0) begin errors++; $display("FAIL timeout_pulse: to=%0d mv=%0d want 0 0", early, mv); end
    endtask

    task automatic test_back_to_back;
        int e0, bad, n;
        @(negedge clk);
        s_valid = 1'b1; s_xin = 16'sd33; s_din = 16'sd50;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        f_update = 1'b1; f_yout = -16'sd50;
        @(negedge clk);
        f_update = 1'b0;
        n = 0;
        while (!m_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (m_valid !== 1'b1 || m_eout !== 16'sd100 || f_err !== 16'sd6) begin errors++; $display("FAIL bp_out: val=%b eout=%0d err=%0d want 1 100 6", m_valid, m_eout, f_err); end
        e0 = en_cnt; bad = 0;
        s_valid = 1'b1; s_xin = 16'sd999; s_din = 16'sd999;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_eout !== 16'sd100 || s_ready !== 1'b0) bad++;
        end
        s_valid = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: %0d bad cycles want 0", bad); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL bp_release: val=%b rdy=%b want 0 1", m_valid, s_ready); end
        checks++; if (en_cnt !== e0 || f_xin !== 16'sd33) begin errors++; $display("FAIL bp_no_accept: en=%0d xin=%0d want %0d 33", en_cnt - e0, f_xin, 0); end
    endtask

    task automatic test_reset_mid;
        int mv;
        @(negedge clk);
        s_valid = 1'b1; s_xin = 16'sd44; s_din = 16'sd55;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        f_update = 1'b1; f_yout = 16'sd123;
        @(negedge clk);
        f_update = 1'b0;
        mv = 0;
        repeat (4) begin @(negedge clk); mv |= int'(m_valid); end
        checks++; if (mv !== 0 || m_yout !== 16'sd0 || f_err !== 16'sd0 || s_ready !== 1'b1) begin errors++; $display("FAIL rst_stray_update: mv=%0d yout=%0d err=%0d rdy=%b want 0 0 0 1", mv, m_yout, f_err, s_ready); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_basic;
        test_saturate;
        test_floor;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
